// File: rtl/ibex_pkg.sv
// Shared LSU response types: per-request metadata and the load align/extend helper.
package ibex_pkg;

  typedef enum logic [1:0] {
    LSU_TYPE_WORD = 2'b00,
    LSU_TYPE_HALF = 2'b01,
    LSU_TYPE_BYTE = 2'b10
  } lsu_type_e;

  typedef struct packed {
    logic      is_load;
    lsu_type_e data_type;
    logic      sign_ext;
    logic [1:0] offset;
    logic      split_first;
  } lsu_resp_meta_t;

  // For split accesses the current response supplies the high bytes, the held first part the low bytes.
  function automatic logic [31:0] lsu_align_load(lsu_resp_meta_t meta,
                                                 logic [31:0]    rdata,
                                                 logic [31:0]    hold);
    logic [31:0] res;
    logic [15:0] half;
    logic [7:0]  byte_d;
    res    = '0;
    half   = '0;
    byte_d = '0;
    case (meta.data_type)
      LSU_TYPE_WORD: begin
        case (meta.offset)
          2'd0:    res = rdata;
          2'd1:    res = {rdata[7:0],  hold[31:8]};
          2'd2:    res = {rdata[15:0], hold[31:16]};
          default: res = {rdata[23:0], hold[31:24]};
        endcase
      end
      LSU_TYPE_HALF: begin
        case (meta.offset)
          2'd0:    half = rdata[15:0];
          2'd1:    half = rdata[23:8];
          2'd2:    half = rdata[31:16];
          default: half = {rdata[7:0], hold[31:24]};
        endcase
        res = meta.sign_ext ? {{16{half[15]}}, half} : {16'h0000, half};
      end
      LSU_TYPE_BYTE: begin
        case (meta.offset)
          2'd0:    byte_d = rdata[7:0];
          2'd1:    byte_d = rdata[15:8];
          2'd2:    byte_d = rdata[23:16];
          default: byte_d = rdata[31:24];
        endcase
        res = meta.sign_ext ? {{24{byte_d[7]}}, byte_d} : {24'h000000, byte_d};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ibex_lsu_meta_fifo.sv
// Metadata FIFO for outstanding LSU bus requests; pointers carry an extra wrap bit to tell full from empty.
module ibex_lsu_meta_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth    = 2,
  parameter bit          ResetAll = 1'b0
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           push_i,
  input  lsu_resp_meta_t push_data_i,
  input  logic           pop_i,
  output lsu_resp_meta_t head_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0]    wr_ptr_q, rd_ptr_q;
  lsu_resp_meta_t mem_q [Depth];
  logic           push_en, pop_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop_en)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Payload only needs a reset when every datapath flop must come up known.
  if (ResetAll) begin : g_mem_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      end else if (push_en) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
    end
  end else begin : g_mem_nr
    always_ff @(posedge clk_i) begin
      if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/ibex_load_resp_stage.sv
// LSU response stage: pairs bus responses with queued metadata, stitches split accesses, aligns load data.
// Optional IBEX_LOAD_RESP_REG_OUT_EN registers the writeback-facing outputs (1-cycle latency).
module ibex_load_resp_stage
  import ibex_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          ResetAll       = 1'b0
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           issue_valid_i,
  output logic           issue_ready_o,
  input  lsu_resp_meta_t issue_meta_i,
  input  logic           data_rvalid_i,
  input  logic [31:0]    data_rdata_i,
  input  logic           data_err_i,
  output logic [31:0]    rf_wdata_lsu_o,
  output logic           rf_we_lsu_o,
  output logic           lsu_resp_valid_o,
  output logic           lsu_resp_err_o,
  output logic           busy_o,
  output logic           spurious_resp_o
);

  lsu_resp_meta_t head;
  logic           fifo_full, fifo_empty;
  logic           push, pop, pop_first, pop_final;
  logic [31:0]    hold_q;
  logic           err_q;
  logic [31:0]    resp_wdata;
  logic           resp_we, resp_valid, resp_err;

  assign issue_ready_o = ~fifo_full;
  assign push          = issue_valid_i & issue_ready_o;
  assign pop           = data_rvalid_i & ~fifo_empty;
  assign pop_first     = pop & head.split_first;
  assign pop_final     = pop & ~head.split_first;

  ibex_lsu_meta_fifo #(
    .Depth    (MaxOutstanding),
    .ResetAll (ResetAll)
  ) u_meta_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i (issue_meta_i),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Sticky error spans both halves of a split access and clears once the final part is reported.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (pop_first) begin
      err_q <= err_q | data_err_i;
    end else if (pop_final) begin
      err_q <= 1'b0;
    end
  end

  if (ResetAll) begin : g_hold_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        hold_q <= '0;
      end else if (pop_first) begin
        hold_q <= data_rdata_i;
      end
    end
  end else begin : g_hold_nr
    always_ff @(posedge clk_i) begin
      if (pop_first) hold_q <= data_rdata_i;
    end
  end

  always_comb begin
    resp_valid = pop_final;
    resp_err   = pop_final & (err_q | data_err_i);
    resp_we    = pop_final & head.is_load & ~resp_err;
    resp_wdata = '0;
    if (resp_we) resp_wdata = lsu_align_load(head, data_rdata_i, hold_q);
  end

  assign spurious_resp_o = data_rvalid_i & fifo_empty;

`ifdef IBEX_LOAD_RESP_REG_OUT_EN
  // Busy covers the cycle in which the registered response is still waiting to be presented.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_wdata_lsu_o   <= '0;
      rf_we_lsu_o      <= 1'b0;
      lsu_resp_valid_o <= 1'b0;
      lsu_resp_err_o   <= 1'b0;
    end else begin
      rf_wdata_lsu_o   <= resp_wdata;
      rf_we_lsu_o      <= resp_we;
      lsu_resp_valid_o <= resp_valid;
      lsu_resp_err_o   <= resp_err;
    end
  end

  assign busy_o = ~fifo_empty | lsu_resp_valid_o;
`else
  assign rf_wdata_lsu_o   = resp_wdata;
  assign rf_we_lsu_o      = resp_we;
  assign lsu_resp_valid_o = resp_valid;
  assign lsu_resp_err_o   = resp_err;
  assign busy_o           = ~fifo_empty;
`endif

`ifndef SYNTHESIS
  issue_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(issue_valid_i && !issue_ready_o))
    else $error("[ibex_load_resp_stage] request issued while metadata FIFO full");

  rvalid_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(data_rvalid_i && fifo_empty))
    else $warning("[ibex_load_resp_stage] bus response with no outstanding request");
`endif

endmodule
